// File: rtl/rr_burst_arbiter.sv
// Four-requester round-robin arbiter with burst tenure and a registered, one-hot grant output.
// Defining RR_ARB_LOCK_EN adds a lock input that extends the current tenure past MAX_BURST.
module rr_burst_arbiter #(
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned CNT_W     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic       req2,
    input  logic       req3,
`ifdef RR_ARB_LOCK_EN
    input  logic       lock,
`endif
    output logic       gnt0,
    output logic       gnt1,
    output logic       gnt2,
    output logic       gnt3,
    output logic [1:0] gnt_id,
    output logic       busy
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] OneCnt = CNT_W'(1);

    state_e           state_q, state_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       id_q, id_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;

    logic [3:0] req;
    logic [3:0] others;
    logic       owner_req;
    logic       at_max;
    logic       hold_lock;
    logic [1:0] win_idle;
    logic [1:0] win_rot;

    // Lowest offset from start wins; iterating downwards leaves the nearest match assigned last.
    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] start);
        logic [1:0] w;
        logic [1:0] idx;
        w = start;
        for (int i = 3; i >= 0; i--) begin
            idx = start + i[1:0];
            if (r[idx]) w = idx;
        end
        return w;
    endfunction

    assign req       = {req3, req2, req1, req0};
    assign owner_req = req[id_q];
    assign others    = req & ~(4'b0001 << id_q);
    assign at_max    = (cnt_q >= MaxCnt);
    assign win_idle  = pick(req, ptr_q);
    assign win_rot   = pick(others, id_q + 2'd1);

`ifdef RR_ARB_LOCK_EN
    assign hold_lock = lock & owner_req;
`else
    assign hold_lock = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    state_d = StGrant;
                    gnt_d   = 4'b0001 << win_idle;
                    id_d    = win_idle;
                    ptr_d   = win_idle + 2'd1;
                    cnt_d   = OneCnt;
                end
            end
            StGrant: begin
                if (owner_req && !at_max) begin
                    cnt_d = cnt_q + OneCnt;
                end else if (owner_req && hold_lock) begin
                    cnt_d = MaxCnt;
                end else if (|others) begin
                    // Handover at the same edge, so the resource never sees an idle cycle.
                    gnt_d = 4'b0001 << win_rot;
                    id_d  = win_rot;
                    ptr_d = win_rot + 2'd1;
                    cnt_d = OneCnt;
                end else if (owner_req) begin
                    cnt_d = OneCnt;
                end else begin
                    state_d = StIdle;
                    gnt_d   = 4'b0000;
                    cnt_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d = |gnt_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            gnt_q   <= 4'b0000;
            id_q    <= 2'd0;
            ptr_q   <= 2'd0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt0   = gnt_q[0];
    assign gnt1   = gnt_q[1];
    assign gnt2   = gnt_q[2];
    assign gnt3   = gnt_q[3];
    assign gnt_id = id_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Directed bench for rr_burst_arbiter: the driver queues the expected grant for every edge,
// and a monitor compares the registered outputs against it on each falling edge.
module tb_rr_burst_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       lock;
    logic       gnt0, gnt1, gnt2, gnt3;
    logic [1:0] gnt_id;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [3:0] exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rr_burst_arbiter #(
        .MAX_BURST(4),
        .CNT_W    (3)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req0  (req[0]),
        .req1  (req[1]),
        .req2  (req[2]),
        .req3  (req[3]),
`ifdef RR_ARB_LOCK_EN
        .lock  (lock),
`endif
        .gnt0  (gnt0),
        .gnt1  (gnt1),
        .gnt2  (gnt2),
        .gnt3  (gnt3),
        .gnt_id(gnt_id),
        .busy  (busy)
    );

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
        end
    endtask

    // Apply inputs for n edges, queueing the expected grant vector after each edge.
    task automatic run(input int n, input logic r, input logic [3:0] rq, input logic lk,
                       input logic [3:0] egnt);
        for (int i = 0; i < n; i++) begin
            rst  = r;
            req  = rq;
            lock = lk;
            @(posedge clk);
            exp_q.push_back(egnt);
            #1;
        end
    endtask

    initial begin : monitor
        logic [3:0] e;
        logic [1:0] eid;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                eid = 2'd0;
                for (int k = 0; k < 4; k++) if (e[k]) eid = 2'(k);
                chk("gnt", {gnt3, gnt2, gnt1, gnt0}, e);
                chk("busy", {3'b000, busy}, {3'b000, |e});
                if (|e) chk("gnt_id", {2'b00, gnt_id}, {2'b00, eid});
            end
        end
    end

    initial begin : driver
        rst  = 1'b1;
        req  = 4'b0000;
        lock = 1'b0;
        // Reset held with every request asserted, then full round robin at MAX_BURST=4.
        run(3, 1'b1, 4'b1111, 1'b0, 4'b0000);
        run(4, 1'b0, 4'b1111, 1'b0, 4'b0001);
        run(4, 1'b0, 4'b1111, 1'b0, 4'b0010);
        run(4, 1'b0, 4'b1111, 1'b0, 4'b0100);
        run(4, 1'b0, 4'b1111, 1'b0, 4'b1000);
        run(1, 1'b0, 4'b1111, 1'b0, 4'b0001);
        run(1, 1'b0, 4'b0000, 1'b0, 4'b0000);
        // Lone requester keeps its grant past the burst limit; drops one edge after req falls.
        run(10, 1'b0, 4'b0010, 1'b0, 4'b0010);
        run(2, 1'b0, 4'b0000, 1'b0, 4'b0000);
        // Owner drops early -> immediate handover; returning requester waits for expiry.
        run(1, 1'b1, 4'b0000, 1'b0, 4'b0000);
        run(2, 1'b0, 4'b0101, 1'b0, 4'b0001);
        run(1, 1'b0, 4'b0100, 1'b0, 4'b0100);
        run(3, 1'b0, 4'b0101, 1'b0, 4'b0100);
        run(1, 1'b0, 4'b0101, 1'b0, 4'b0001);
        // Reset pulse inside the gnt2 tenure sends the pointer back to 0.
        run(3, 1'b0, 4'b1111, 1'b0, 4'b0001);
        run(4, 1'b0, 4'b1111, 1'b0, 4'b0010);
        run(2, 1'b0, 4'b1111, 1'b0, 4'b0100);
        run(1, 1'b1, 4'b1111, 1'b0, 4'b0000);
        run(4, 1'b0, 4'b1111, 1'b0, 4'b0001);
        run(1, 1'b0, 4'b1111, 1'b0, 4'b0010);
`ifdef RR_ARB_LOCK_EN
        run(1, 1'b1, 4'b0000, 1'b0, 4'b0000);
        run(10, 1'b0, 4'b0011, 1'b1, 4'b0001);
        run(1, 1'b0, 4'b0011, 1'b0, 4'b0010);
`endif
        req = 4'b0000;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
